midi_note_tx: RTL and testbench



---
 rtl/midi_note_tx.sv | 172 +++++++++++++++++
 tb/tb_midi_note_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_tx.sv
// MIDI note-on/off serialiser: 8N1, LSB first, status/note/velocity.
// Define MIDI_TX_RUNNING_STATUS_EN to omit repeated status bytes.
module midi_note_tx #(
  parameter int         CLK_FREQ = 50000000,
  parameter int         BAUD     = 31250,
  parameter logic [3:0] CHANNEL  = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic       note_on_in,
  input  logic [6:0] note_num_in,
  input  logic [6:0] velocity_in,
  output logic       ready,
  output logic       tx
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("midi_note_tx: CLK_FREQ/BAUD must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_nxt;
  logic [1:0]       r_byte;
  logic [1:0]       w_byte_nxt;
  logic             r_ready;
  logic             w_ready_nxt;
  logic             r_tx;
  logic             w_tx_nxt;
  logic [7:0]       r_status;
  logic [6:0]       r_note;
  logic [6:0]       r_vel;
  logic             w_accept;
  logic             w_tick;
  logic             w_skip;
  logic [7:0]       w_status_new;
  logic [7:0]       w_cur;

  assign w_accept     = valid_in & r_ready;
  assign w_tick       = (r_cnt == CNT_W'(DIV - 1));
  assign w_status_new = {note_on_in ? 4'h9 : 4'h8, CHANNEL};
  assign ready        = r_ready;
  assign tx           = r_tx;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] r_last_status;
  logic       r_rs_valid;

  assign w_skip = r_rs_valid && (w_status_new == r_last_status);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_status <= 8'h00;
      r_rs_valid    <= 1'b0;
    end else if (w_accept && !w_skip) begin
      r_last_status <= w_status_new;
      r_rs_valid    <= 1'b1;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_status <= 8'h00;
      r_note   <= 7'h00;
      r_vel    <= 7'h00;
    end else if (w_accept) begin
      r_status <= w_status_new;
      r_note   <= note_num_in;
      r_vel    <= velocity_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_byte  <= 2'd0;
      r_ready <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_ready <= w_ready_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_cur = {1'b0, r_vel};
    unique case (w_byte_nxt)
      2'd0:    w_cur = r_status;
      2'd1:    w_cur = {1'b0, r_note};
      default: w_cur = {1'b0, r_vel};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_tick ? '0 : r_cnt + CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_ready_nxt = r_ready;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt   = '0;
        w_ready_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt = START;
          w_bit_nxt   = 3'd0;
          w_byte_nxt  = w_skip ? 2'd1 : 2'd0;
          w_ready_nxt = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_bit_nxt   = 3'd0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit == 3'd7) w_state_nxt = STOP;
          else w_bit_nxt = r_bit + 3'd1;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_byte == 2'd2) begin
            w_state_nxt = IDLE;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = START;
            w_byte_nxt  = r_byte + 2'd1;
          end
        end
      end
    endcase
  end

  // tx is registered from the next-state view so it never glitches
  always_comb begin
    w_tx_nxt = 1'b1;
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_cur[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_midi_note_tx.sv
// Self-checking bench for midi_note_tx: table of note events plus
// back-to-back, mid-frame valid, and reset-abort sequences.
module tb_midi_note_tx;

  localparam int CLK_FREQ = 80;
  localparam int BAUD     = 10;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic       note_on_in = 1'b0;
  logic [6:0] note_num_in = 7'h00;
  logic [6:0] velocity_in = 7'h00;
  logic       ready;
  logic       tx;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       m_rs_valid = 1'b0;
  logic [7:0] m_last = 8'h00;

  typedef struct {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  midi_note_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .CHANNEL (4'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .note_on_in (note_on_in),
    .note_num_in(note_num_in),
    .velocity_in(velocity_in),
    .ready      (ready),
    .tx         (tx)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // UART receiver: samples each bit at its centre on the falling edge
  logic       m_act = 1'b0;
  int         m_t = 0;
  logic [9:0] m_bits = '0;

  task automatic finish_byte();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_byte actual=%0h required=none", m_bits[8:1]);
    end else begin
      e = exp_q.pop_front();
      chk("byte", {24'h0, m_bits[8:1]}, {24'h0, e});
      chk("framing", {30'h0, m_bits[9], m_bits[0]}, 32'h2);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (tx === 1'b0) begin
        m_act = 1'b1;
        m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t % DIV == DIV / 2) begin
        m_bits[m_t / DIV] = tx;
        if (m_t / DIV == 9) begin
          finish_byte();
          m_act = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_msg(input logic on, input logic [6:0] note,
                           input logic [6:0] vel, output int n);
    logic [7:0] st;
    st = {on ? 4'h9 : 4'h8, 4'h0};
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (m_rs_valid && st == m_last) begin
      n = 2;
    end else begin
      n = 3;
      m_last = st;
      m_rs_valid = 1'b1;
    end
`else
    n = 3;
`endif
    if (n == 3) exp_q.push_back(st);
    exp_q.push_back({1'b0, note});
    exp_q.push_back({1'b0, vel});
    valid_in = 1'b1;
    note_on_in = on;
    note_num_in = note;
    velocity_in = vel;
  endtask

  task automatic wait_accept(input string name);
    int   k;
    logic r;
    bit   ok;
    k = 0;
    ok = 0;
    while (k < 40 * DIV) begin
      r = ready;
      step();
      k++;
      if (r === 1'b1) begin
        ok = 1;
        break;
      end
    end
    valid_in = 1'b0;
    note_on_in = 1'($urandom);
    note_num_in = 7'($urandom);
    velocity_in = 7'($urandom);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout actual=0 required=1", name);
    end else begin
      chk({name, "_start"}, {31'h0, tx}, 32'h0);
      chk({name, "_busy"}, {31'h0, ready}, 32'h0);
    end
  endtask

  task automatic measure(input string name, input int n, input int k0);
    int k;
    k = k0;
    while (ready !== 1'b1 && k < n * 10 * DIV + 50) begin
      step();
      k++;
    end
    chk({name, "_lat"}, k, n * 10 * DIV);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int na;
    int nb;
    int lows;

    vecs[0] = '{on: 1'b1, note: 7'h3C, vel: 7'h40};
    vecs[1] = '{on: 1'b0, note: 7'h3C, vel: 7'h00};
    vecs[2] = '{on: 1'b1, note: 7'h7F, vel: 7'h7F};
    vecs[3] = '{on: 1'b0, note: 7'h00, vel: 7'h01};

    repeat (3) step();
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", {31'h0, ready}, 32'h1);

    for (int i = 0; i < 4; i++) begin
      drive_msg(vecs[i].on, vecs[i].note, vecs[i].vel, n);
      wait_accept($sformatf("vec%0d", i));
      measure($sformatf("vec%0d", i), n, 0);
    end

    // second event held valid while busy; taken on the cycle ready returns
    drive_msg(1'b1, 7'h10, 7'h20, na);
    wait_accept("b2b_a");
    drive_msg(1'b1, 7'h11, 7'h21, nb);
    measure("b2b_a", na, 0);
    wait_accept("b2b_b");
    measure("b2b_b", nb, 0);

    drive_msg(1'b1, 7'h45, 7'h33, n);
    wait_accept("midpulse");
    repeat (5 * DIV) step();
    valid_in = 1'b1;
    note_on_in = 1'b0;
    note_num_in = 7'h01;
    velocity_in = 7'h01;
    step();
    valid_in = 1'b0;
    chk("midpulse_busy", {31'h0, ready}, 32'h0);
    measure("midpulse", n, 5 * DIV + 1);

    drive_msg(1'b1, 7'h55, 7'h2A, n);
    wait_accept("abort");
    repeat (13 * DIV) step();
    reset = 1'b1;
    step();
    chk("abort_tx", {31'h0, tx}, 32'h1);
    chk("abort_ready", {31'h0, ready}, 32'h0);
    exp_q.delete();
    m_rs_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("abort_rel_ready", {31'h0, ready}, 32'h1);
    lows = 0;
    for (int i = 0; i < 40 * DIV; i++) begin
      if (tx !== 1'b1) lows++;
      step();
    end
    chk("no_resume", lows, 0);

    drive_msg(1'b1, 7'h3C, 7'h40, n);
    wait_accept("after_abort");
    measure("after_abort", n, 0);

    repeat (2 * DIV) step();
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
